// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: D-stage hazard detection for the pipeline stall controller.
// Keeps shadow E/M destination records and compares them with D-stage operands
// using Tuse/Tnew. Also owns the multiply/divide busy counter and stalls HI/LO
// users while it is nonzero.
// Optional build macro HAZARD_STATS_EN adds saturating stall/MDU-stall counters.
module hazard_stall_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        D_valid,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_rs_tuse,
  input  logic [1:0]  D_rt_tuse,
  input  logic [4:0]  D_waddr,
  input  logic [1:0]  D_tnew,
  input  logic        D_md_start,
  input  logic        D_is_div,
  input  logic        D_md_use,
`ifdef HAZARD_STATS_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] md_stall_cnt,
`endif
  output logic        stall,
  output logic        md_busy
);

  // Destination record carried by each shadowed stage.
  typedef struct packed {
    logic [4:0] waddr;
    logic [1:0] tnew;
  } rec_t;

  localparam rec_t BUBBLE = '{waddr: 5'd0, tnew: 2'd0};
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

  rec_t             e_q, e_d;
  rec_t             m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic haz_e_rs, haz_e_rt, haz_m_rs, haz_m_rt, haz_md;

  // One cycle closer to forwardable; a ready result stays ready.
  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // A source hazards when the record will not have its value by the time it is used.
  function automatic logic src_haz(input logic       valid,
                                   input logic [4:0] src,
                                   input logic [1:0] tuse,
                                   input rec_t       rec);
    return valid && (src != 5'd0) && (src == rec.waddr) && (tuse < rec.tnew);
  endfunction

  // Combinational hazard terms and stall; zero-cycle latency to the controller.
  always_comb begin
    haz_e_rs = src_haz(D_valid, D_rs, D_rs_tuse, e_q);
    haz_e_rt = src_haz(D_valid, D_rt, D_rt_tuse, e_q);
    haz_m_rs = src_haz(D_valid, D_rs, D_rs_tuse, m_q);
    haz_m_rt = src_haz(D_valid, D_rt, D_rt_tuse, m_q);
    haz_md   = D_valid && D_md_use && (cnt_q != '0);
    stall    = haz_e_rs | haz_e_rt | haz_m_rs | haz_m_rt | haz_md;
    md_busy  = (cnt_q != '0);
  end

  // Next-state: advance records, insert bubble on stall, load or count down MDU.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    e_d   = BUBBLE;
    m_d   = '{waddr: e_q.waddr, tnew: sat_dec(e_q.tnew)};
    cnt_d = cnt_q;
    if (D_valid && !stall) begin
      e_d = '{waddr: D_waddr, tnew: D_tnew};
    end
    if (D_valid && D_md_start && !stall) begin
      cnt_d = D_is_div ? DIV_LD : MULT_LD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // State registers; reset discards all in-flight records and the MDU count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q   <= BUBBLE;
      m_q   <= BUBBLE;
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values together.
      e_q   <= e_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] md_stall_cnt_q, md_stall_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    md_stall_cnt_d = md_stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (haz_md && (md_stall_cnt_q != 32'hFFFF_FFFF)) begin
      md_stall_cnt_d = md_stall_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q    <= '0;
      md_stall_cnt_q <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      md_stall_cnt_q <= md_stall_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign md_stall_cnt = md_stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed scenarios plus random traffic, checked against a
// model that tracks in-flight producers by age and the MDU by its free cycle.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_waddr;
  logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic       d_md_start, d_is_div, d_md_use;
  logic       stall, md_busy;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, md_stall_cnt;
`endif

  hazard_stall_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .D_valid    (d_valid),
    .D_rs       (d_rs),
    .D_rt       (d_rt),
    .D_rs_tuse  (d_rs_tuse),
    .D_rt_tuse  (d_rt_tuse),
    .D_waddr    (d_waddr),
    .D_tnew     (d_tnew),
    .D_md_start (d_md_start),
    .D_is_div   (d_is_div),
    .D_md_use   (d_md_use),
`ifdef HAZARD_STATS_EN
    .stall_cnt    (stall_cnt),
    .md_stall_cnt (md_stall_cnt),
`endif
    .stall      (stall),
    .md_busy    (md_busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: producers that have entered E, with age in cycles since entry.
  typedef struct {
    int waddr;
    int tnew;
    int age;
  } prod_t;
  prod_t prods[$];
  int    cyc;
  int    md_free;
  int    m_stalls;
  int    m_md_stalls;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic model_reset();
    prods.delete();
    cyc         = 0;
    md_free     = 0;
    m_stalls    = 0;
    m_md_stalls = 0;
  endtask

  // A result is still outstanding for (tnew - age) cycles; the reader needs it after tuse.
  task automatic model_eval(output bit st, output bit mdh);
    st  = 1'b0;
    mdh = d_valid && d_md_use && (cyc < md_free);
    foreach (prods[i]) begin
      int rem;
      rem = prods[i].tnew - prods[i].age;
      if (rem < 0) rem = 0;
      if (d_valid && d_rs != 0 && int'(d_rs) == prods[i].waddr && int'(d_rs_tuse) < rem) st = 1'b1;
      if (d_valid && d_rt != 0 && int'(d_rt) == prods[i].waddr && int'(d_rt_tuse) < rem) st = 1'b1;
    end
    if (mdh) st = 1'b1;
  endtask

  task automatic drive(input bit v, input int rs, input int rst, input int rt, input int rtt,
                       input int wa, input int tn, input bit mds, input bit dv, input bit mdu);
    d_valid    = v;
    d_rs       = 5'(rs);
    d_rs_tuse  = 2'(rst);
    d_rt       = 5'(rt);
    d_rt_tuse  = 2'(rtt);
    d_waddr    = 5'(wa);
    d_tnew     = 2'(tn);
    d_md_start = mds;
    d_is_div   = dv;
    d_md_use   = mdu;
    #3;
  endtask

  task automatic idle();
    drive(0, 0, 3, 0, 3, 0, 0, 0, 0, 0);
  endtask

  // Check against the model, clock one edge, and advance the model.
  task automatic adv();
    bit   st, mdh;
    prod_t nq[$];
    model_eval(st, mdh);
    chk("stall_model", {31'd0, stall}, {31'd0, st});
    chk("md_busy_model", {31'd0, md_busy}, {31'd0, (cyc < md_free)});
`ifdef HAZARD_STATS_EN
    chk("stall_cnt_model", stall_cnt, m_stalls);
    chk("md_stall_cnt_model", md_stall_cnt, m_md_stalls);
`endif
    @(posedge clk);
    if (st)  m_stalls++;
    if (mdh) m_md_stalls++;
    foreach (prods[i]) if (prods[i].age == 0) nq.push_back('{prods[i].waddr, prods[i].tnew, 1});
    if (d_valid && !st) begin
      nq.push_back('{int'(d_waddr), int'(d_tnew), 0});
      if (d_md_start) md_free = cyc + 1 + (d_is_div ? 10 : 5);
    end
    prods = nq;
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    #1;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_md_busy", {31'd0, md_busy}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    do_reset();

    // Load-use: lw $8 (tnew 2), then add reading $8 at E.
    drive(1, 0, 3, 0, 3, 8, 2, 0, 0, 0);
    chk("lw_no_stall", {31'd0, stall}, 32'd0);
    adv();
    drive(1, 8, 1, 0, 3, 10, 1, 0, 0, 0);
    chk("lu_stall", {31'd0, stall}, 32'd1);
    adv();
    drive(1, 8, 1, 0, 3, 10, 1, 0, 0, 0);
    chk("lu_release", {31'd0, stall}, 32'd0);
    adv();
    idle(); adv(); idle(); adv();

    // div then mflo: 10 cycles of MDU stall.
    drive(1, 1, 0, 2, 0, 0, 0, 1, 1, 1);
    chk("div_issue", {31'd0, stall}, 32'd0);
    adv();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 3, 0, 3, 3, 1, 0, 0, 1);
      chk("div_mflo_stall", {31'd0, stall}, 32'd1);
      chk("div_busy", {31'd0, md_busy}, 32'd1);
      adv();
    end
    drive(1, 0, 3, 0, 3, 3, 1, 0, 0, 1);
    chk("div_mflo_go", {31'd0, stall}, 32'd0);
    chk("div_idle", {31'd0, md_busy}, 32'd0);
    adv();
    idle();
`ifdef HAZARD_STATS_EN
    chk("stats_stall_cnt", stall_cnt, 32'd11);
    chk("stats_md_stall_cnt", md_stall_cnt, 32'd10);
`endif
    adv();

    // mult then mflo: 5 cycles.
    drive(1, 1, 0, 2, 0, 0, 0, 1, 0, 1);
    adv();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 3, 0, 3, 3, 1, 0, 0, 1);
      chk("mult_mflo_stall", {31'd0, stall}, 32'd1);
      chk("mult_busy", {31'd0, md_busy}, 32'd1);
      adv();
    end
    drive(1, 0, 3, 0, 3, 3, 1, 0, 0, 1);
    chk("mult_mflo_go", {31'd0, stall}, 32'd0);
    chk("mult_idle", {31'd0, md_busy}, 32'd0);
    adv();
    idle(); adv(); idle(); adv();

    // add $9 (tnew 1) then beq reading $9 at D.
    drive(1, 0, 3, 0, 3, 9, 1, 0, 0, 0);
    adv();
    drive(1, 9, 0, 0, 3, 0, 0, 0, 0, 0);
    chk("beq_stall", {31'd0, stall}, 32'd1);
    adv();
    drive(1, 9, 0, 0, 3, 0, 0, 0, 0, 0);
    chk("beq_release", {31'd0, stall}, 32'd0);
    adv();
    idle(); adv(); idle(); adv();

    // Same producer, reader needs it at E: no stall; rt path exercised too.
    drive(1, 0, 3, 0, 3, 9, 1, 0, 0, 0);
    adv();
    drive(1, 0, 3, 9, 1, 0, 0, 0, 0, 0);
    chk("tuse1_no_stall", {31'd0, stall}, 32'd0);
    adv();
    idle(); adv(); idle(); adv();

    // Writer of $0 never hazards.
    drive(1, 0, 3, 0, 3, 0, 2, 0, 0, 0);
    adv();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("r0_no_stall", {31'd0, stall}, 32'd0);
    adv();
    idle(); adv();

    // Reset during a load-use stall with the MDU busy.
    drive(1, 1, 0, 2, 0, 0, 0, 1, 0, 1);
    adv();
    drive(1, 0, 3, 0, 3, 8, 2, 0, 0, 0);
    adv();
    drive(1, 8, 1, 8, 1, 10, 1, 0, 0, 0);
    chk("mid_stall", {31'd0, stall}, 32'd1);
    chk("mid_busy", {31'd0, md_busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_drops_stall", {31'd0, stall}, 32'd0);
    chk("rst_drops_busy", {31'd0, md_busy}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    drive(1, 8, 1, 8, 1, 10, 1, 0, 0, 0);
    chk("post_rst_no_stall", {31'd0, stall}, 32'd0);
    adv();

    // Random traffic over a small register set to provoke frequent hazards.
    for (int i = 0; i < 400; i++) begin
      bit mds;
      mds = ($urandom % 8) == 0;
      drive(($urandom % 5) != 0, $urandom % 4, $urandom % 4, $urandom % 4, $urandom % 4,
            $urandom % 4, $urandom % 3, mds, $urandom % 2, mds || (($urandom % 6) == 0));
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
